// File: rtl/perf_window_monitor_if.sv
// rtl/perf_window_monitor_if.sv - control, event and readout bundle for perf_window_monitor
interface perf_window_monitor_if #(
    parameter int CNT_W  = 32,
    parameter int NUM_EV = 4,
    parameter int PC_W   = 32,
    parameter int SEL_W  = $clog2(NUM_EV + 1)
);
    logic              start;
    logic              stop;
    logic [NUM_EV-1:0] ev_valid;
    logic [PC_W-1:0]   pc_in;
    logic [SEL_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              busy;
    logic              done;
`ifdef PERF_PC_TRACE_EN
    logic [PC_W-1:0]   last_pc;
`endif

    modport master (
        output start, stop, ev_valid, pc_in, rd_sel,
        input  rd_data, busy, done
`ifdef PERF_PC_TRACE_EN
        , input last_pc
`endif
    );

    modport slave (
        input  start, stop, ev_valid, pc_in, rd_sel,
        output rd_data, busy, done
`ifdef PERF_PC_TRACE_EN
        , output last_pc
`endif
    );
endinterface

// File: rtl/perf_window_monitor.sv
// rtl/perf_window_monitor.sv - cycle-window performance counter bank, optional PC trace via PERF_PC_TRACE_EN
module perf_window_monitor #(
    parameter int CNT_W  = 32,
    parameter int NUM_EV = 4,
    parameter int WINDOW = 1000,
    parameter int PC_W   = 32,
    parameter int SEL_W  = $clog2(NUM_EV + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    perf_window_monitor_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);
    localparam bit               WIN_EN  = (WINDOW != 0);

    state_t           state;
    state_t           state_nxt;
    logic             clear;
    logic             count;
    logic             win_end;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ev_cnt [NUM_EV];
    logic [CNT_W-1:0] rd_nxt;

    // Saturating increment: the window end compares against the value this edge will store.
    assign cyc_inc = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
    assign win_end = WIN_EN && (cyc_inc == WIN_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        count     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                    clear     = 1'b1;
                end
            end
            S_RUN: begin
                count = 1'b1;
                if (bus.stop || win_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            for (int i = 0; i < NUM_EV; i++) begin
                ev_cnt[i] <= '0;
            end
        end else if (clear) begin
            cyc_cnt <= '0;
            for (int i = 0; i < NUM_EV; i++) begin
                ev_cnt[i] <= '0;
            end
        end else if (count) begin
            cyc_cnt <= cyc_inc;
            for (int i = 0; i < NUM_EV; i++) begin
                if (bus.ev_valid[i] && (ev_cnt[i] != CNT_MAX)) begin
                    ev_cnt[i] <= ev_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Selector values past the cycle counter read as zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_nxt = ev_cnt[i];
            end
        end
        if (bus.rd_sel == SEL_W'(NUM_EV)) begin
            rd_nxt = cyc_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_nxt;
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);

`ifdef PERF_PC_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.last_pc <= '0;
        end else if (clear) begin
            bus.last_pc <= '0;
        end else if (count) begin
            bus.last_pc <= bus.pc_in;
        end
    end
`endif
endmodule

// File: tb/tb_perf_window_monitor.sv
// tb/tb_perf_window_monitor.sv - directed checks of perf_window_monitor over three parameter sets
module tb_perf_window_monitor;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    perf_window_monitor_if #(.CNT_W(32), .NUM_EV(4), .PC_W(32), .SEL_W(3)) bus_m();
    perf_window_monitor_if #(.CNT_W(4),  .NUM_EV(4), .PC_W(32), .SEL_W(3)) bus_s();
    perf_window_monitor_if #(.CNT_W(32), .NUM_EV(4), .PC_W(32), .SEL_W(3)) bus_p();

    perf_window_monitor #(.CNT_W(32), .NUM_EV(4), .WINDOW(1000), .PC_W(32), .SEL_W(3))
        u_main (.clk(clk), .rst(rst), .bus(bus_m.slave));
    perf_window_monitor #(.CNT_W(4), .NUM_EV(4), .WINDOW(0), .PC_W(32), .SEL_W(3))
        u_sat (.clk(clk), .rst(rst), .bus(bus_s.slave));
    perf_window_monitor #(.CNT_W(32), .NUM_EV(4), .WINDOW(8), .PC_W(32), .SEL_W(3))
        u_pc (.clk(clk), .rst(rst), .bus(bus_p.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", bus_m.busy, bus_m.done); end
        tick();
        tick();
        rst = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bus_m.rd_sel = 3'(s);
            tick();
            checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL reset_read sel=%0d: got %0d expected 0", s, bus_m.rd_data); end
        end
        checks++; if (bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin errors++; $display("FAIL idle_flags: busy=%b done=%b expected 0 0", bus_m.busy, bus_m.done); end
    endtask

    task automatic test_full_window();
        int n = 0;
        bus_m.start = 1'b1;
        tick();
        bus_m.start = 1'b0;
        checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", bus_m.busy); end
        while (bus_m.busy === 1'b1 && n < 1100) begin
            bus_m.ev_valid = {2'b00, (n % 2 == 0), 1'b1};
            tick();
            n++;
        end
        bus_m.ev_valid = '0;
        checks++; if (n != 1000) begin errors++; $display("FAIL window_busy_cycles: got %0d expected 1000", n); end
        checks++; if (bus_m.done !== 1'b1 || bus_m.busy !== 1'b0) begin errors++; $display("FAIL window_done: done=%b busy=%b expected 1 0", bus_m.done, bus_m.busy); end
        bus_m.rd_sel = 3'd4; tick();
        checks++; if (bus_m.rd_data !== 32'd1000) begin errors++; $display("FAIL window_cyc: got %0d expected 1000", bus_m.rd_data); end
        bus_m.rd_sel = 3'd0; tick();
        checks++; if (bus_m.rd_data !== 32'd1000) begin errors++; $display("FAIL window_ch0: got %0d expected 1000", bus_m.rd_data); end
        bus_m.rd_sel = 3'd1; tick();
        checks++; if (bus_m.rd_data !== 32'd500) begin errors++; $display("FAIL window_ch1: got %0d expected 500", bus_m.rd_data); end
        bus_m.rd_sel = 3'd2; tick();
        checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL window_ch2: got %0d expected 0", bus_m.rd_data); end
    endtask

    task automatic test_early_stop();
        bus_m.start  = 1'b1;
        bus_m.rd_sel = 3'd4;
        tick();
        bus_m.start = 1'b0;
        checks++; if (bus_m.busy !== 1'b1 || bus_m.done !== 1'b0) begin errors++; $display("FAIL restart_flags: busy=%b done=%b expected 1 0", bus_m.busy, bus_m.done); end
        for (int n = 0; n < 37; n++) begin
            if (n == 36) begin
                bus_m.stop     = 1'b1;
                bus_m.ev_valid = 4'b0100;
            end
            tick();
            if (n == 0) begin
                checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL restart_clear: got %0d expected 0", bus_m.rd_data); end
            end
        end
        bus_m.stop     = 1'b0;
        bus_m.ev_valid = '0;
        checks++; if (bus_m.done !== 1'b1 || bus_m.busy !== 1'b0) begin errors++; $display("FAIL stop_done: done=%b busy=%b expected 1 0", bus_m.done, bus_m.busy); end
        tick();
        checks++; if (bus_m.rd_data !== 32'd37) begin errors++; $display("FAIL stop_cyc: got %0d expected 37", bus_m.rd_data); end
        bus_m.rd_sel = 3'd2; tick();
        checks++; if (bus_m.rd_data !== 32'd1) begin errors++; $display("FAIL stop_ch2: got %0d expected 1", bus_m.rd_data); end
        bus_m.rd_sel = 3'd0; tick();
        checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL stop_ch0: got %0d expected 0", bus_m.rd_data); end
        bus_m.stop = 1'b1; tick();
        bus_m.stop = 1'b0; tick();
        bus_m.rd_sel = 3'd4; tick();
        checks++; if (bus_m.done !== 1'b1 || bus_m.rd_data !== 32'd37) begin errors++; $display("FAIL stop_in_done: done=%b cyc=%0d expected 1 37", bus_m.done, bus_m.rd_data); end
    endtask

    task automatic test_async_reset();
        bus_m.start  = 1'b1;
        bus_m.rd_sel = 3'd4;
        tick();
        bus_m.start    = 1'b0;
        bus_m.ev_valid = 4'b0001;
        repeat (10) tick();
        checks++; if (bus_m.rd_data !== 32'd9) begin errors++; $display("FAIL midrun_cyc: got %0d expected 9", bus_m.rd_data); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (bus_m.busy !== 1'b0 || bus_m.done !== 1'b0 || bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL async_reset: busy=%b done=%b rd=%0d expected 0 0 0", bus_m.busy, bus_m.done, bus_m.rd_data); end
        #1;
        rst = 1'b1;
        repeat (5) tick();
        checks++; if (bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", bus_m.busy, bus_m.done); end
        tick();
        checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL post_reset_cyc: got %0d expected 0", bus_m.rd_data); end
        bus_m.rd_sel = 3'd0; tick();
        checks++; if (bus_m.rd_data !== 32'd0) begin errors++; $display("FAIL post_reset_ch0: got %0d expected 0", bus_m.rd_data); end
        bus_m.ev_valid = '0;
    endtask

    task automatic test_saturation();
        bus_s.start = 1'b1;
        tick();
        bus_s.start    = 1'b0;
        bus_s.ev_valid = 4'b0001;
        repeat (20) tick();
        checks++; if (bus_s.busy !== 1'b1) begin errors++; $display("FAIL sat_unbounded: busy=%b expected 1", bus_s.busy); end
        bus_s.ev_valid = '0;
        bus_s.stop     = 1'b1;
        tick();
        bus_s.stop = 1'b0;
        checks++; if (bus_s.done !== 1'b1) begin errors++; $display("FAIL sat_done: got %b expected 1", bus_s.done); end
        bus_s.rd_sel = 3'd0; tick();
        checks++; if (bus_s.rd_data !== 4'd15) begin errors++; $display("FAIL sat_ch0: got %0d expected 15", bus_s.rd_data); end
        bus_s.rd_sel = 3'd4; tick();
        checks++; if (bus_s.rd_data !== 4'd15) begin errors++; $display("FAIL sat_cyc: got %0d expected 15", bus_s.rd_data); end
        bus_s.rd_sel = 3'd1; tick();
        checks++; if (bus_s.rd_data !== 4'd0) begin errors++; $display("FAIL sat_ch1: got %0d expected 0", bus_s.rd_data); end
    endtask

    task automatic test_pc_trace();
        int n = 0;
        bus_p.start = 1'b1;
        tick();
        bus_p.start = 1'b0;
        while (bus_p.busy === 1'b1 && n < 20) begin
            bus_p.pc_in = 32'h0040_0000 + 32'(4 * n);
            tick();
            n++;
        end
        checks++; if (n != 8 || bus_p.done !== 1'b1) begin errors++; $display("FAIL pc_window: cycles=%0d done=%b expected 8 1", n, bus_p.done); end
`ifdef PERF_PC_TRACE_EN
        checks++; if (bus_p.last_pc !== 32'h0040_001C) begin errors++; $display("FAIL last_pc: got %h expected 0040001c", bus_p.last_pc); end
`endif
        bus_p.pc_in  = 32'hDEAD_BEEF;
        bus_p.rd_sel = 3'd4;
        tick();
        checks++; if (bus_p.rd_data !== 32'd8) begin errors++; $display("FAIL pc_cyc: got %0d expected 8", bus_p.rd_data); end
`ifdef PERF_PC_TRACE_EN
        checks++; if (bus_p.last_pc !== 32'h0040_001C) begin errors++; $display("FAIL last_pc_hold: got %h expected 0040001c", bus_p.last_pc); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        bus_m.start = 1'b0; bus_m.stop = 1'b0; bus_m.ev_valid = '0; bus_m.pc_in = '0; bus_m.rd_sel = '0;
        bus_s.start = 1'b0; bus_s.stop = 1'b0; bus_s.ev_valid = '0; bus_s.pc_in = '0; bus_s.rd_sel = '0;
        bus_p.start = 1'b0; bus_p.stop = 1'b0; bus_p.ev_valid = '0; bus_p.pc_in = '0; bus_p.rd_sel = '0;
        test_reset();
        test_full_window();
        test_early_stop();
        test_async_reset();
        test_saturation();
        test_pc_trace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perf_window_monitor.md
# perf_window_monitor

Synthesizable cycle-window performance monitor that replaces fixed-length benchmark runs with an in-design measurement block. It attaches beside `mips_pipeline`, counts clock cycles and up to `NUM_EV` event pulses (e.g. retired instructions, branches, mispredicts) over a programmable window, then freezes the results for readout. It generalises a fixed 1000-cycle run with a final-PC report into a parametrised, restartable, multi-channel counter bank.

## Interface
- `CNT_W`, 32: width of every counter and of `rd_data`.
- `NUM_EV`, 4: number of event channels (≥1).
- `WINDOW`, 1000: cycles per measurement window; 0 = unbounded (runs until `stop`).
- `PC_W`, 32: width of `pc_in` / `last_pc`.
- `SEL_W`, `$clog2(NUM_EV+1)`: width of `rd_sel`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new window; clears all counters.
- `stop` in 1: end the window early.
- `ev_valid` in NUM_EV: per-channel event strobe, one count per high cycle.
- `pc_in` in PC_W: current pipeline PC (IF stage).
- `rd_sel` in SEL_W: 0..NUM_EV-1 selects an event counter; NUM_EV selects the cycle counter; other values read 0.
- `rd_data` out CNT_W: registered readout of the selected counter.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `last_pc` out PC_W: present only with `PERF_PC_TRACE_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start`=1 → RUN; all counters and `last_pc` cleared at that edge. `stop` ignored.
- RUN: on each edge, `cyc_cnt` increments; `ev_cnt[i]` increments when `ev_valid[i]`=1. The cycle in which `stop` is sampled is counted, then → DONE. When `WINDOW`≠0 and the incremented `cyc_cnt` equals `WINDOW`, → DONE. `stop` and the window end on the same cycle → DONE, with identical counts. `start` is ignored in RUN.
- DONE: all counters frozen and readable indefinitely. `start` → RUN with clear (restart). `stop` ignored.
- Counters saturate at 2^CNT_W−1 and never wrap. This applies to `cyc_cnt` as well, which matters when `WINDOW`=0.
- `ev_valid` outside RUN is ignored.
- `rd_data` updates on every edge in all states and is independent of the FSM.
- Reset asserted mid-window: immediate return to IDLE with all state zeroed. No partial results are retained.

## Timing
- Reset values: `rd_data`=0, `busy`=0, `done`=0, `last_pc`=0, all counters 0, state IDLE.
- `start` sampled at edge N: `busy`=1 after edge N. The first counted cycle is the one following edge N, at edge N+1.
- With `WINDOW`=W and no `stop`: exactly W cycles are counted. `busy` falls and `done` rises after edge N+W, with `cyc_cnt`=W.
- `stop` sampled at edge M in RUN: that cycle is counted, and `done`=1 after edge M.
- Readout latency is 1 cycle: `rd_sel` sampled at edge K → `rd_data` valid after edge K.
- `busy` and `done` are mutually exclusive and are registered state decodes, with no combinational path from inputs.

## Configuration
- `PERF_PC_TRACE_EN` defined:
  - `last_pc` port exists.
  - It registers `pc_in` on every RUN cycle, including the terminating cycle, so in DONE it holds the PC of the final counted cycle.
  - It is cleared on `start` and on reset, and holds its value in IDLE and DONE.
- Undefined: `last_pc` port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset and readout: `rst`=0 then 1, sweep `rd_sel` 0..NUM_EV+1 → `rd_data`=0 each; `busy`=`done`=0.
- Full window: `WINDOW`=1000, pulse `start`, hold `ev_valid[0]`=1 throughout and toggle `ev_valid[1]` every other cycle → `done` after exactly 1000 counted cycles; cycle counter=1000, ch0=1000, ch1=500; `busy` high for exactly 1000 cycles.
- Early stop with simultaneous event: `start`, then `stop` together with `ev_valid[2]`=1 on the 37th RUN cycle → cycle counter=37, ch2=1; stop during DONE does nothing.
- Saturation: `CNT_W`=4, `WINDOW`=0, `ev_valid[0]`=1 for 20 cycles, then `stop` → ch0=15, cycle counter=15, no wrap.
- Restart and async reset: `start` in DONE → all counters 0 on the first RUN cycle. Assert `rst`=0 mid-window, asynchronously between edges → outputs 0 immediately, state IDLE, no counting until the next `start`.
- `PERF_PC_TRACE_EN`: drive `pc_in`=0x0040_0000+4·cycle, `WINDOW`=8 → `last_pc`=0x0040_001C in DONE; a build without the macro elaborates with no `last_pc` port.
